// File: rtl/maxpool_pkg.sv
// rtl/maxpool_pkg.sv - shared constants, FSM state type and window address helper
// Purpose: one place for the data width, map geometry and window pixel address math
//   used by the scheduler, its address generator, its interface and the pool unit.
// Ports: none (package).
package maxpool_pkg;
  localparam int DATA_W       = 22;
  localparam int IMG_W        = 16;
  localparam int IMG_H        = 16;
  localparam int WIN          = 4;
  localparam int NPIX         = WIN * WIN;
  localparam int ADDR_W       = 8;
  localparam int OADDR_W      = 4;
  localparam int POOL_TIMEOUT = 8;

  localparam int WX_N  = IMG_W / WIN;
  localparam int WY_N  = IMG_H / WIN;
  localparam int WX_W  = $clog2(WX_N);
  localparam int WY_W  = $clog2(WY_N);
  localparam int K_W   = $clog2(NPIX + 1);
  localparam int PIX_W = $clog2(NPIX);
  localparam int TO_W  = $clog2(POOL_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, FETCH, POOL, WRITE, FIN} state_t;

  // Memory address of pixel k (row-major inside the window) of window (wx, wy).
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [WX_W-1:0] wx,
                                                 input logic [WY_W-1:0] wy,
                                                 input logic [K_W-1:0]  k);
    int a;
    a = (int'(wy) * WIN + int'(k) / WIN) * IMG_W + int'(wx) * WIN + int'(k) % WIN;
    return ADDR_W'(a);
  endfunction
endpackage

// File: rtl/maxpool_window_sched_if.sv
// rtl/maxpool_window_sched_if.sv - memory, pool unit and output buffer bus of the scheduler
// Purpose: bundles the input-memory read port, the pool unit handshake and the output
//   buffer write port.
// Ports (master = scheduler side):
//   rd_en/rd_addr out, rd_data in         input memory, data one cycle after rd_en
//   win_data/pool_en out, pool_done/pool_result in   pool unit
//   wr_en/wr_addr/wr_data out             output buffer
interface maxpool_window_sched_if;
  import maxpool_pkg::*;

  logic                     rd_en;
  logic [ADDR_W-1:0]        rd_addr;
  logic [DATA_W-1:0]        rd_data;
  logic [NPIX*DATA_W-1:0]   win_data;
  logic                     pool_en;
  logic                     pool_done;
  logic [DATA_W-1:0]        pool_result;
  logic                     wr_en;
  logic [OADDR_W-1:0]       wr_addr;
  logic [DATA_W-1:0]        wr_data;

  modport master (
    output rd_en, rd_addr, win_data, pool_en, wr_en, wr_addr, wr_data,
    input  rd_data, pool_done, pool_result
  );

  modport slave (
    input  rd_en, rd_addr, win_data, pool_en, wr_en, wr_addr, wr_data,
    output rd_data, pool_done, pool_result
  );
endinterface

// File: rtl/maxpool_addr_gen.sv
// rtl/maxpool_addr_gen.sv - window and pixel counters with read/write address generation
// Purpose: tracks the current window (wx, wy) and the fetch pixel counter k, and derives
//   the input read address, the output write address and the last-window flag.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   init              restart at window (0,0), k=0
//   k_step, k_clr     advance / clear the fetch pixel counter
//   win_adv           move to the next window (row-major, wraps)
//   k                 fetch pixel counter (0..NPIX)
//   rd_addr, wr_addr  addresses for pixel k of the current window / its result slot
//   last_win          current window is the bottom-right one
module maxpool_addr_gen
  import maxpool_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               init,
  input  logic               k_step,
  input  logic               k_clr,
  input  logic               win_adv,
  output logic [K_W-1:0]     k,
  output logic [ADDR_W-1:0]  rd_addr,
  output logic [OADDR_W-1:0] wr_addr,
  output logic               last_win
);
  logic [WX_W-1:0] wx;
  logic [WY_W-1:0] wy;
  logic            wx_max;
  logic            wy_max;

  assign wx_max = (wx == WX_W'(WX_N - 1));
  assign wy_max = (wy == WY_W'(WY_N - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wx <= '0;
      wy <= '0;
      k  <= '0;
    end else if (init) begin
      wx <= '0;
      wy <= '0;
      k  <= '0;
    end else begin
      if (k_clr)       k <= '0;
      else if (k_step) k <= k + K_W'(1);
      if (win_adv) begin
        if (wx_max) begin
          wx <= '0;
          wy <= wy_max ? '0 : wy + WY_W'(1);
        end else begin
          wx <= wx + WX_W'(1);
        end
      end
    end
  end

  assign rd_addr  = pix_addr(wx, wy, k);
  assign wr_addr  = OADDR_W'(int'(wy) * WX_N + int'(wx));
  assign last_win = wx_max && wy_max;
endmodule

// File: rtl/maxpool_window_sched.sv
// rtl/maxpool_window_sched.sv - window fetch / pool / write sequencer for max pooling
// Purpose: walks the feature map window by window, loads 16 pixels into a register bank,
//   hands them to the pool unit and writes each pooled result to the output buffer.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   start        request to pool the whole map (only honoured in IDLE)
//   busy         run in progress
//   done         one-cycle pulse after the last window is written
//   err          sticky pool-unit timeout flag, cleared by the next accepted start
//   bus          master side of maxpool_window_sched_if
module maxpool_window_sched
  import maxpool_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done,
  output logic err,
  maxpool_window_sched_if.master bus
);
  state_t             state, state_nx;
  logic [K_W-1:0]     k;
  logic [ADDR_W-1:0]  addr_rd;
  logic [OADDR_W-1:0] addr_wr;
  logic               last_win;
  logic [DATA_W-1:0]  pix [NPIX];
  logic [DATA_W-1:0]  result;
  logic [TO_W-1:0]    pcnt;
  logic               err_q;
  logic [PIX_W-1:0]   cap_idx;
  logic               init, k_step, k_clr, win_adv;
  logic               rd_en, pool_en, wr_en;
  logic               pool_hit, pool_expire;
  logic [NPIX*DATA_W-1:0] win_flat;

  maxpool_addr_gen u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .init     (init),
    .k_step   (k_step),
    .k_clr    (k_clr),
    .win_adv  (win_adv),
    .k        (k),
    .rd_addr  (addr_rd),
    .wr_addr  (addr_wr),
    .last_win (last_win)
  );

  // The unit registers its inputs on the first pool_en cycle, so pool_done is only
  // trusted once pool_en has already been high for at least one cycle.
  assign pool_hit    = (state == POOL) && (pcnt != '0) && bus.pool_done;
  assign pool_expire = (state == POOL) && (pcnt == TO_W'(POOL_TIMEOUT - 1)) && !pool_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    init     = 1'b0;
    k_step   = 1'b0;
    k_clr    = 1'b0;
    win_adv  = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    rd_en    = 1'b0;
    pool_en  = 1'b0;
    wr_en    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          init     = 1'b1;
          state_nx = FETCH;
        end
      end
      FETCH: begin
        busy   = 1'b1;
        rd_en  = (k < K_W'(NPIX));
        k_step = 1'b1;
        if (k == K_W'(NPIX)) begin
          k_clr    = 1'b1;
          state_nx = POOL;
        end
      end
      POOL: begin
        busy    = 1'b1;
        pool_en = 1'b1;
        if (pool_hit)         state_nx = WRITE;
        else if (pool_expire) state_nx = IDLE;
      end
      WRITE: begin
        busy     = 1'b1;
        wr_en    = 1'b1;
        win_adv  = 1'b1;
        state_nx = last_win ? FIN : FETCH;
      end
      FIN: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Read data lags rd_en by one cycle, so fetch cycle k lands pixel k-1.
  assign cap_idx = PIX_W'(k - K_W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NPIX; i++) pix[i] <= '0;
      result <= '0;
      pcnt   <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == FETCH && k != '0) pix[cap_idx] <= bus.rd_data;
      pcnt <= (state == POOL) ? pcnt + TO_W'(1) : '0;
      if (pool_hit) result <= bus.pool_result;
      if (state == IDLE && start) err_q <= 1'b0;
      else if (pool_expire)       err_q <= 1'b1;
    end
  end

  always_comb begin
    win_flat = '0;
    for (int i = 0; i < NPIX; i++) win_flat[i*DATA_W +: DATA_W] = pix[i];
  end

  assign err          = err_q;
  assign bus.rd_en    = rd_en;
  assign bus.rd_addr  = rd_en ? addr_rd : '0;
  assign bus.win_data = win_flat;
  assign bus.pool_en  = pool_en;
  assign bus.wr_en    = wr_en;
  assign bus.wr_addr  = wr_en ? addr_wr : '0;
  assign bus.wr_data  = result;
endmodule

// File: tb/tb_maxpool_window_sched.sv
// tb/tb_maxpool_window_sched.sv - directed self-checking bench for maxpool_window_sched
module tb_maxpool_window_sched;
  import maxpool_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done, err;

  maxpool_window_sched_if bus();

  maxpool_window_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [256];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int pool_mode = 0;  // 0: done on 2nd pool_en cycle, 1: never, 2: on 1st (bogus) and 3rd
  int pcnt_m = 0;
  logic signed [DATA_W-1:0] pmax;
  int wr_addr_q[$];
  int wr_data_q[$];
  int rd_addr_q[$];
  int n_done = 0;
  int n_clash = 0;
  int n_pool_cyc = 0;

  // memory and pool unit models
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    pcnt_m <= bus.pool_en ? pcnt_m + 1 : 0;
  end

  always_comb begin
    pmax = bus.win_data[DATA_W-1:0];
    for (int i = 1; i < NPIX; i++)
      if ($signed(bus.win_data[i*DATA_W +: DATA_W]) > pmax) pmax = bus.win_data[i*DATA_W +: DATA_W];
  end

  assign bus.pool_done   = bus.pool_en && ((pool_mode == 0 && pcnt_m == 1) ||
                                           (pool_mode == 2 && (pcnt_m == 0 || pcnt_m == 2)));
  assign bus.pool_result = (pool_mode == 2 && pcnt_m == 0) ? 22'h0ABCDE : pmax;

  always @(negedge clk) begin
    if (bus.wr_en) begin
      wr_addr_q.push_back(int'(bus.wr_addr));
      wr_data_q.push_back(int'(bus.wr_data));
    end
    if (bus.rd_en) rd_addr_q.push_back(int'(bus.rd_addr));
    if (done) n_done++;
    if (bus.pool_en) n_pool_cyc++;
    if ((bus.rd_en && bus.pool_en) || (bus.wr_en && (bus.rd_en || bus.pool_en))) n_clash++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
    n_done = 0;
    n_clash = 0;
    n_pool_cyc = 0;
  endtask

  task automatic fill_mem_linear();
    for (int a = 0; a < 256; a++) mem[a] = DATA_W'(a);
  endtask

  task automatic pulse_start(output int s);
    @(negedge clk);
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int end_cyc, output bit ok);
    ok = 1'b0;
    end_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      if (done || !busy) begin
        end_cyc = cyc;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_err"}, err, 0);
    check_eq({tag, "_rd_en"}, bus.rd_en, 0);
    check_eq({tag, "_pool_en"}, bus.pool_en, 0);
    check_eq({tag, "_wr_en"}, bus.wr_en, 0);
    check_eq({tag, "_rd_addr"}, bus.rd_addr, 0);
    check_eq({tag, "_wr_addr"}, bus.wr_addr, 0);
    check_eq({tag, "_wr_data"}, bus.wr_data, 0);
    check_eq({tag, "_win_zero"}, (bus.win_data == '0), 1);
    check_eq({tag, "_state"}, dut.state, IDLE);
  endtask

  // Full-map run; per_win is the expected cycles per window.
  task automatic run_full(input string tag, input int per_win, input bit poke_start);
    int s, e;
    bit ok;
    clear_logs();
    pulse_start(s);
    check_eq({tag, "_err_cleared"}, err, 0);
    check_eq({tag, "_busy_after_start"}, busy, 1);
    if (poke_start) begin
      fork
        begin
          repeat (16) @(negedge clk);
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
          repeat (40) @(negedge clk);
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
      join_none
    end
    wait_idle(2000, e, ok);
    @(negedge clk);
    check_eq({tag, "_ended"}, ok, 1);
    check_eq({tag, "_done_cycle"}, e - s, 16 * per_win + 1);
    check_eq({tag, "_n_done"}, n_done, 1);
    check_eq({tag, "_n_writes"}, wr_addr_q.size(), 16);
    check_eq({tag, "_n_reads"}, rd_addr_q.size(), 256);
    check_eq({tag, "_clash"}, n_clash, 0);
    check_eq({tag, "_err_end"}, err, 0);
    check_eq({tag, "_busy_end"}, busy, 0);
  endtask

  task automatic check_linear_results(input string tag);
    for (int i = 0; i < 16; i++) begin
      int exp_v;
      exp_v = ((i / 4) * 4 + 3) * 16 + (i % 4) * 4 + 3;
      if (i < wr_addr_q.size()) begin
        check_eq($sformatf("%s_wr_addr%0d", tag, i), wr_addr_q[i], i);
        check_eq($sformatf("%s_wr_data%0d", tag, i), wr_data_q[i], exp_v);
      end
    end
  endtask

  initial begin
    int s, e;
    bit ok;

    fill_mem_linear();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;

    // reset mid-fetch
    pulse_start(s);
    repeat (5) @(negedge clk);
    check_eq("pre_rst_rd_en", bus.rd_en, 1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    clear_logs();
    repeat (30) @(negedge clk);
    check_eq("midrst_no_wr", wr_addr_q.size(), 0);
    check_eq("midrst_no_pool", n_pool_cyc, 0);
    check_eq("midrst_idle_busy", busy, 0);

    // full map, mem[a] = a
    run_full("lin", 20, 1'b0);
    check_linear_results("lin");
    for (int j = 0; j < 16; j++) begin
      int exp_a;
      exp_a = (8 + j / 4) * 16 + 4 + j % 4;
      if (9 * 16 + j < rd_addr_q.size())
        check_eq($sformatf("addr_w9_%0d", j), rd_addr_q[9 * 16 + j], exp_a);
    end

    // negative data in window 0
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) mem[r * 16 + c] = -22'sd5;
    mem[19] = -22'sd1;
    run_full("neg", 20, 1'b0);
    if (wr_addr_q.size() > 1) begin
      check_eq("neg_wr_addr0", wr_addr_q[0], 0);
      check_eq("neg_wr_data0", wr_data_q[0], 22'h3FFFFF);
      check_eq("neg_wr_data1", wr_data_q[1], 55);
    end
    fill_mem_linear();

    // pool unit never answers
    pool_mode = 1;
    clear_logs();
    pulse_start(s);
    wait_idle(200, e, ok);
    @(negedge clk);
    check_eq("to_ended", ok, 1);
    check_eq("to_idle_cycle", e - s, 26);
    check_eq("to_err", err, 1);
    check_eq("to_busy", busy, 0);
    check_eq("to_n_done", n_done, 0);
    check_eq("to_n_wr", wr_addr_q.size(), 0);
    check_eq("to_pool_cycles", n_pool_cyc, POOL_TIMEOUT);
    repeat (3) @(negedge clk);
    check_eq("to_err_sticky", err, 1);

    pool_mode = 0;
    run_full("after_to", 20, 1'b0);
    check_linear_results("after_to");

    // early pool_done on first pool_en cycle plus start pulses while busy
    pool_mode = 2;
    run_full("early", 21, 1'b1);
    check_linear_results("early");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
